// File: rtl/fib_pkg.sv
// fib_pkg: shared defaults and state encoding for the Fibonacci sequencer
package fib_pkg;
  localparam int FIB_WIDTH = 12;
  localparam int FIB_NIB   = 4;
  localparam int FIB_NW    = 5;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_e;
endpackage

// File: rtl/fib_add_chain.sv
// fib_add_chain: a+b built from NIB-wide ripple-carry slices, carry chained slice to slice
module fib_add_chain #(
  parameter int WIDTH = 12,
  parameter int NIB   = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);
  logic [WIDTH:0] c;
  assign c[0] = 1'b0;
  for (genvar s = 0; s < WIDTH / NIB; s++) begin : g_s
    for (genvar i = 0; i < NIB; i++) begin : g_b
      localparam int K = s * NIB + i;
      assign sum[K]   = a[K] ^ b[K] ^ c[K];
      assign c[K + 1] = (a[K] & b[K]) | (c[K] & (a[K] ^ b[K]));
    end
  end
  assign carry_out = c[WIDTH];
endmodule

// File: rtl/fib_seq_ctrl.sv
// fib_seq_ctrl: valid/ready F(n) sequencer over an iterative add loop; FIB_SEQ_SAT_EN saturates on overflow
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH,
  parameter int NIB   = FIB_NIB,
  parameter int NW    = FIB_NW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [NW-1:0]    req_n,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_f,
  output logic             rsp_ovf,
  output logic             busy
);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, f_q, f_d, sum, res;
  logic [NW-1:0]    cnt_q, cnt_d;
  logic             ovf_q, ovf_d, rovf_q, rovf_d, co, last;
  fib_add_chain #(.WIDTH(WIDTH), .NIB(NIB)) u_add (
    .a        (a_q),
    .b        (b_q),
    .sum      (sum),
    .carry_out(co)
  );
  assign last = cnt_q[NW-1:1] == '0;
`ifdef FIB_SEQ_SAT_EN
  assign res = ovf_q ? '1 : (cnt_q[0] ? b_q : a_q);
`else
  assign res = cnt_q[0] ? b_q : a_q;
`endif
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    f_d     = f_q;
    rovf_d  = rovf_q;
    case (state_q)
      IDLE: if (req_valid) begin
        a_d     = '0;
        b_d     = WIDTH'(1);
        cnt_d   = req_n;
        ovf_d   = 1'b0;
        state_d = CALC;
      end
      CALC: if (last) begin
        f_d     = res;
        rovf_d  = ovf_q;
        state_d = RESP;
      end else begin
        a_d   = b_q;
        b_d   = sum;
        ovf_d = ovf_q | co;
        cnt_d = cnt_q - NW'(1);
      end
      RESP: state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= WIDTH'(1);
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      f_q     <= '0;
      rovf_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      f_q     <= f_d;
      rovf_q  <= rovf_d;
    end
  end
  assign req_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign busy      = state_q != IDLE;
  assign rsp_f     = f_q;
  assign rsp_ovf   = rovf_q;
endmodule

// File: tb/tb_fib_seq_ctrl.sv
// tb_fib_seq_ctrl: directed vectors with a queue scoreboard checked by a handshake monitor
module tb_fib_seq_ctrl;
  typedef struct {
    int f;
    int o;
    int lat;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_n;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [11:0] rsp_f;
  logic        rsp_ovf;
  logic        busy;
  exp_t        exp_q[$];
  int          asserts = 0;
  int          fails = 0;
  int          cyc = 0;
  int          acc = 0;
  int          lat = 0;
  logic        pv = 1'b0;
`ifdef FIB_SEQ_SAT_EN
  localparam int F19 = 4095;
  localparam int F31 = 4095;
`else
  localparam int F19 = 85;
  localparam int F31 = 2781;
`endif
  fib_seq_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_n    (req_n),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_f    (rsp_f),
    .rsp_ovf  (rsp_ovf),
    .busy     (busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input int act, input int exp);
    asserts++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (!rst_n) pv = 1'b0;
    else begin
      if (req_valid && req_ready) acc = cyc + 1;
      if (rsp_valid && !pv) lat = cyc - acc + 1;
      pv = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) chk("unexpected_rsp", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_f", int'(rsp_f), e.f);
          chk("rsp_ovf", int'(rsp_ovf), e.o);
          chk("latency", lat, e.lat);
        end
      end
    end
  end
  task automatic issue(input int n, input int f, input int o, input int l, input bit push);
    bit done = 1'b0;
    if (push) exp_q.push_back('{f, o, l});
    req_valid = 1'b1;
    req_n = 5'(n);
    for (int i = 0; i < 200 && !done; i++) begin
      done = req_ready;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!done) chk("accept_timeout", 0, 1);
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 200 && !rsp_valid; i++) begin
      @(posedge clk);
      #1;
    end
    chk("valid_timeout", int'(rsp_valid), 1);
  endtask
  task automatic wait_empty();
    for (int i = 0; i < 200 && exp_q.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("rsp_timeout", exp_q.size(), 0);
  endtask
  task automatic chk_reset();
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_rsp_f", int'(rsp_f), 0);
    chk("rst_rsp_ovf", int'(rsp_ovf), 0);
    chk("rst_busy", int'(busy), 0);
  endtask
  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_n = '0;
    rsp_ready = 1'b1;
    #12;
    chk_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(10, 55, 0, 11, 1'b1);
    wait_valid();
    @(posedge clk);
    #1;
    chk("ready_after_rsp", int'(req_ready), 1);
    wait_empty();
    issue(0, 0, 0, 2, 1'b1);
    wait_empty();
    issue(1, 1, 0, 2, 1'b1);
    wait_empty();
    issue(18, 2584, 0, 19, 1'b1);
    wait_empty();
    issue(19, F19, 1, 20, 1'b1);
    wait_empty();
    issue(31, F31, 1, 32, 1'b1);
    wait_empty();
    rsp_ready = 1'b0;
    issue(7, 13, 0, 8, 1'b1);
    wait_valid();
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1;
      req_n = 5'd4;
      chk("hold_valid", int'(rsp_valid), 1);
      chk("hold_f", int'(rsp_f), 13);
      chk("hold_req_ready", int'(req_ready), 0);
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_empty();
    issue(3, 2, 0, 4, 1'b1);
    wait_empty();
    issue(15, 0, 0, 0, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    chk("calc_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    issue(12, 144, 0, 13, 1'b1);
    wait_empty();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/fib_seq_ctrl.md
Name: fib_seq_ctrl

Overview:
- Request/response sequencer that computes F(n) on demand over an iterative two-register add datapath. F(0)=0, F(1)=1.
- Accepts one request at a time on a valid/ready handshake, runs the add loop one step per cycle, then holds the result until the consumer takes it.
- Replaces free-running, initial-block-driven Fibonacci generation with a resettable, restartable, back-pressured unit.

Parameters:
- WIDTH, 12, result and datapath width in bits; must be a multiple of NIB.
- NIB, 4, width of each ripple-carry slice in the adder chain.
- NW, 5, width of the n request field; n ranges 0..2^NW-1.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block idle and able to accept.
- req_n  in  NW  index n, sampled on accept.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes result.
- rsp_f  out  WIDTH  F(n) modulo 2^WIDTH (saturated if the feature is enabled).
- rsp_ovf  out  1  a carry out of bit WIDTH-1 occurred during this computation.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; registers a=0, b=1, cnt=0, ovf=0.
  - Outputs: req_ready=1, rsp_valid=0, rsp_f=0, rsp_ovf=0, busy=0.
- States: IDLE, CALC, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: a<=0, b<=1, cnt<=req_n, ovf<=0, go to CALC.
- CALC: req_ready=0, one step per cycle.
  - If cnt<=1: latch rsp_f <= (cnt==0 ? a : b), rsp_ovf <= ovf, go to RESP.
  - Else: a<=b, b<=sum (a+b truncated to WIDTH), ovf<=ovf|carry_out, cnt<=cnt-1.
- RESP:
  - rsp_valid=1; rsp_f and rsp_ovf held stable while rsp_ready=0.
  - On rsp_ready: rsp_valid<=0, go to IDLE.
  - No request is accepted in the same cycle (req_ready=0 in RESP).
- Latency: rsp_valid is first high max(n,1)+1 rising edges after the accept edge (n=0→2, n=1→2, n=10→11).
- Throughput: one request per max(n,1)+2 cycles, given rsp_ready=1.
- Arithmetic:
  - Adder is a chain of WIDTH/NIB ripple-carry slices; carry-in of slice 0 is 0.
  - carry_out is the carry from the top slice.
  - Sum wraps modulo 2^WIDTH.
- Boundaries:
  - n=0 and n=1 take no add steps.
  - n=2^NW-1 runs to completion with no counter wrap.
  - rsp_f and rsp_ovf hold their last value outside RESP; they are only meaningful while rsp_valid=1.
  - req_valid in CALC/RESP is ignored (held off by req_ready=0).
  - rst_n low mid-CALC or mid-RESP aborts immediately to the reset values; the pending result is lost.

Optional Feature:
- Macro FIB_SEQ_SAT_EN.
- Defined: when the latched ovf=1, rsp_f = all-ones (2^WIDTH-1); rsp_ovf still reports 1.
- Undefined: rsp_f is the wrapped modulo value.
- Handshake and latency are identical in both builds.

Decomposition:
- Shared package fib_pkg:
  - Default WIDTH/NIB/NW constants.
  - State encoding typedef (IDLE=0, CALC=1, RESP=2).
- One sub-module fib_add_chain (WIDTH, NIB): combinational a+b giving sum and carry_out, built from NIB-wide ripple-carry slices.
- The controller instantiates one fib_add_chain.

Test Plan:
- Reset then req_n=10, rsp_ready=1 → rsp_valid 11 edges after accept, rsp_f=55, rsp_ovf=0, req_ready back to 1 the cycle after the response handshake.
- req_n=0, then req_n=1 → rsp_f=0, then rsp_f=1; both with latency 2 and rsp_ovf=0.
- req_n=18 → rsp_f=2584, rsp_ovf=0.
- req_n=19 → rsp_ovf=1; rsp_f=85 (4181 mod 4096) without the macro, 4095 with FIB_SEQ_SAT_EN.
- req_n=7 with rsp_ready held low 5 cycles:
  - rsp_f=13 stable and rsp_valid=1 throughout.
  - req_valid asserted in that window gets req_ready=0.
  - After rsp_ready, a new req_n=3 returns 2.
- req_n=15, drop rst_n at cycle 6 of CALC:
  - All outputs at reset values immediately.
  - After release, req_n=12 → rsp_f=144.
